// File: rtl/input_port_buffer.sv
// Router input port: flit FIFO with header-driven XY route computation and a
// packet-level request/grant handshake toward the switch arbiter.
module input_port_buffer #(
   parameter int         DATA_WIDTH = 32,
   parameter int         DEPTH      = 4,
   parameter logic [1:0] CUR_X      = 2'd0,
   parameter logic [1:0] CUR_Y      = 2'd0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] flit_in,
   input  logic                  flit_in_valid,
   output logic                  ready,
   output logic [4:0]            req,
   input  logic                  grant,
   output logic [DATA_WIDTH-1:0] flit_out,
   output logic                  flit_out_valid,
   output logic                  err
);

   localparam int              AW         = $clog2(DEPTH);
   localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [1:0]      T_INV      = 2'b00;
   localparam logic [1:0]      T_HDR      = 2'b01;
   localparam logic [1:0]      T_TAIL     = 2'b11;

   localparam logic [4:0] R_LOCAL = 5'b00001;
   localparam logic [4:0] R_NORTH = 5'b00010;
   localparam logic [4:0] R_EAST  = 5'b00100;
   localparam logic [4:0] R_SOUTH = 5'b01000;
   localparam logic [4:0] R_WEST  = 5'b10000;

   typedef enum logic {IDLE, ACTIVE} state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [AW:0]           count;
   state_t                state_q, state_d;
   logic [4:0]            req_q, req_d;
   logic                  err_q, err_d;
   logic                  push, pop, empty;
   logic [DATA_WIDTH-1:0] head;
   logic [1:0]            head_type, dest_x, dest_y;
   logic [4:0]            route;

   assign empty     = (count == '0);
   assign ready     = (count < FULL_COUNT);
   assign push      = flit_in_valid && ready && (flit_in[DATA_WIDTH-1 -: 2] != T_INV);
   assign head      = mem[rd_ptr];
   assign head_type = head[DATA_WIDTH-1 -: 2];
   assign dest_x    = head[3:2];
   assign dest_y    = head[1:0];

   assign flit_out  = head;
   assign req       = req_q;
   assign err       = err_q;

   // Dimension-ordered routing: resolve X fully before Y.
   always_comb begin
      route = R_LOCAL;
      if (dest_x > CUR_X)      route = R_EAST;
      else if (dest_x < CUR_X) route = R_WEST;
      else if (dest_y > CUR_Y) route = R_NORTH;
      else if (dest_y < CUR_Y) route = R_SOUTH;
   end

   always_comb begin
      state_d        = state_q;
      req_d          = req_q;
      err_d          = 1'b0;
      pop            = 1'b0;
      flit_out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               if (head_type == T_HDR) begin
                  state_d = ACTIVE;
                  req_d   = route;
               end else begin
                  // Stray body/tail with no open packet: drop it and flag.
                  pop   = 1'b1;
                  err_d = 1'b1;
               end
            end
         end
         ACTIVE: begin
            if (grant && !empty) begin
               pop            = 1'b1;
               flit_out_valid = 1'b1;
               if (head_type == T_TAIL) begin
                  state_d = IDLE;
                  req_d   = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         req_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= flit_in;
   end

endmodule

// File: tb/tb_input_port_buffer.sv
// Bench for input_port_buffer at CUR=(1,1), DEPTH=4: directed packets then
// random traffic, all outputs compared each cycle against a queue-based model.
module tb_input_port_buffer;

   localparam int DW = 32;
   localparam int DP = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] flit_in = '0;
   logic          flit_in_valid = 1'b0;
   logic          ready;
   logic [4:0]    req;
   logic          grant = 1'b0;
   logic [DW-1:0] flit_out;
   logic          flit_out_valid;
   logic          err;

   int passed = 0;
   int total  = 0;

   logic [31:0] q[$];
   bit          active;
   logic [4:0]  req_m;
   logic        err_m;

   input_port_buffer #(
      .DATA_WIDTH(DW),
      .DEPTH     (DP),
      .CUR_X     (2'd1),
      .CUR_Y     (2'd1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .flit_in       (flit_in),
      .flit_in_valid (flit_in_valid),
      .ready         (ready),
      .req           (req),
      .grant         (grant),
      .flit_out      (flit_out),
      .flit_out_valid(flit_out_valid),
      .err           (err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mkflit(input logic [1:0] t, input logic [1:0] dx,
                                          input logic [1:0] dy);
      logic [25:0] mid;
      mid = 26'($urandom);
      return {t, mid, dx, dy};
   endfunction

   // XY routing from this router at (1,1)
   function automatic logic [4:0] route_of(input logic [31:0] h);
      int dx, dy;
      dx = int'(h[3:2]);
      dy = int'(h[1:0]);
      if (dx > 1) return 5'b00100;
      if (dx < 1) return 5'b10000;
      if (dy > 1) return 5'b00010;
      if (dy < 1) return 5'b01000;
      return 5'b00001;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, expv, $time);
   endtask

   task automatic model_reset();
      q.delete();
      active = 0;
      req_m  = '0;
      err_m  = 1'b0;
   endtask

   task automatic check_outputs();
      bit fov;
      fov = active && grant && (q.size() > 0);
      check("ready", 32'(ready), 32'(q.size() < DP));
      check("req", 32'(req), 32'(req_m));
      check("err", 32'(err), 32'(err_m));
      check("flit_out_valid", 32'(flit_out_valid), 32'(fov));
      if (fov) check("flit_out", flit_out, q[0]);
   endtask

   task automatic model_edge();
      bit          do_push;
      logic [31:0] h;
      if (!rst) begin
         model_reset();
         return;
      end
      do_push = flit_in_valid && (q.size() < DP) && (flit_in[31:30] != 2'b00);
      err_m   = 1'b0;
      if (q.size() > 0) begin
         h = q[0];
         if (active) begin
            if (grant) begin
               void'(q.pop_front());
               if (h[31:30] == 2'b11) begin
                  active = 0;
                  req_m  = '0;
               end
            end
         end else if (h[31:30] == 2'b01) begin
            active = 1;
            req_m  = route_of(h);
         end else begin
            void'(q.pop_front());
            err_m = 1'b1;
         end
      end
      if (do_push) q.push_back(flit_in);
   endtask

   task automatic step(input logic v, input logic [31:0] d, input logic g);
      flit_in_valid = v;
      flit_in       = d;
      grant         = g;
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic send_packet(input logic [1:0] dx, input logic [1:0] dy);
      step(1'b1, mkflit(2'b01, dx, dy), 1'b1);
      step(1'b1, mkflit(2'b10, 2'd0, 2'd0), 1'b1);
      step(1'b1, mkflit(2'b11, 2'd0, 2'd0), 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
   endtask

   initial begin
      logic [1:0] t;
      logic       v, g;
      int         r;

      model_reset();
      #1;
      check("reset_ready", 32'(ready), 32'd1);
      check("reset_req", 32'(req), 32'd0);
      check("reset_fov", 32'(flit_out_valid), 32'd0);
      check("reset_err", 32'(err), 32'd0);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0);
      rst = 1'b1;

      // one packet per output direction
      send_packet(2'd1, 2'd1);
      send_packet(2'd2, 2'd1);
      send_packet(2'd0, 2'd1);
      send_packet(2'd1, 2'd2);
      send_packet(2'd1, 2'd0);

      // fill with grant low, fifth flit refused
      step(1'b1, mkflit(2'b01, 2'd2, 2'd1), 1'b0);
      step(1'b1, mkflit(2'b10, 2'd0, 2'd0), 1'b0);
      step(1'b1, mkflit(2'b10, 2'd0, 2'd0), 1'b0);
      step(1'b1, mkflit(2'b10, 2'd0, 2'd0), 1'b0);
      step(1'b1, mkflit(2'b11, 2'd0, 2'd0), 1'b0);
      check("full_not_ready", 32'(ready), 32'd0);
      // drain while still offering flits
      step(1'b1, mkflit(2'b10, 2'd0, 2'd0), 1'b1);
      step(1'b1, mkflit(2'b10, 2'd0, 2'd0), 1'b1);
      step(1'b1, mkflit(2'b11, 2'd0, 2'd0), 1'b1);
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

      // stray body in IDLE, then an invalid-type flit
      step(1'b1, mkflit(2'b10, 2'd0, 2'd0), 1'b0);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0);
      step(1'b1, mkflit(2'b00, 2'd2, 2'd2), 1'b0);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0);

      // reset mid-packet with two flits held and East requested
      step(1'b1, mkflit(2'b01, 2'd3, 2'd1), 1'b0);
      step(1'b1, mkflit(2'b10, 2'd0, 2'd0), 1'b0);
      step(1'b0, '0, 1'b0);
      check("pre_reset_req", 32'(req), 32'b00100);
      #2;
      rst = 1'b0;
      #1;
      check("async_req", 32'(req), 32'd0);
      check("async_ready", 32'(ready), 32'd1);
      check("async_fov", 32'(flit_out_valid), 32'd0);
      model_reset();
      step(1'b0, '0, 1'b1);
      rst = 1'b1;
      step(1'b0, '0, 1'b1);
      send_packet(2'd1, 2'd3);

      // random traffic
      for (int i = 0; i < 500; i++) begin
         r = int'($urandom_range(0, 9));
         t = (r < 2) ? 2'b01 : (r < 6) ? 2'b10 : (r < 9) ? 2'b11 : 2'b00;
         v = ($urandom_range(0, 3) != 0);
         g = ($urandom_range(0, 2) != 0);
         step(v, mkflit(t, 2'($urandom), 2'($urandom)), g);
      end
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
